// File: rtl/serv_fpu_pkg.sv
// Shared encodings for the serv FP extension responder: opcode groups, flag
// bit positions, the canonical NaN and the handshake FSM states.
package serv_fpu_pkg;

    localparam logic [4:0] F5_SGNJ   = 5'b00100;
    localparam logic [4:0] F5_MINMAX = 5'b00101;
    localparam logic [4:0] F5_CMP    = 5'b10100;
    localparam logic [4:0] F5_MVXCLS = 5'b11100;
    localparam logic [4:0] F5_MVWX   = 5'b11110;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/serv_fpu_cls.sv
// Combinational single-precision field classifier shared by both operands.
module serv_fpu_cls (
    input  logic [31:0] word,
    output logic        is_nan,
    output logic        is_snan,
    output logic        is_zero,
    output logic        is_sub,
    output logic        is_inf,
    output logic        sign
);

    logic [7:0]  exponent;
    logic [22:0] mantissa;
    logic        exp_max;
    logic        exp_min;
    logic        mant_zero;

    assign exponent  = word[30:23];
    assign mantissa  = word[22:0];
    assign exp_max   = (exponent == 8'hFF);
    assign exp_min   = (exponent == 8'h00);
    assign mant_zero = (mantissa == 23'd0);

    assign is_nan  = exp_max & ~mant_zero;
    assign is_snan = is_nan & ~mantissa[22];
    assign is_inf  = exp_max & mant_zero;
    assign is_zero = exp_min & mant_zero;
    assign is_sub  = exp_min & ~mant_zero;
    assign sign    = word[31];

endmodule

// File: rtl/serv_fpu_resp.sv
// Responder for the core's extension operand interface: captures rs1/rs2,
// runs the non-arithmetic single-precision ops and returns one o_ready pulse.
module serv_fpu_resp
    import serv_fpu_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter bit FLAGS_EN    = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [4:0]  i_funct5,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic [31:0] o_rd,
    output logic        o_ready,
    input  logic        i_fflags_clr,
    output logic [4:0]  o_fflags
);

    localparam logic [1:0] CNT_LAST = 2'(EXEC_CYCLES - 1);

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  op_f5;
    logic [2:0]  op_f3;

    logic a_nan, a_snan, a_zero, a_sub, a_inf, a_sign;
    logic b_nan, b_snan, b_zero, b_sub, b_inf, b_sign;
    logic a_norm, any_nan, any_snan, both_zero;
    logic lt_ord, flt, feq, exec_done, cls_unused;
    logic [9:0]  fclass;
    logic [31:0] result;
    logic [4:0]  op_flags;

    serv_fpu_cls u_cls_a (
        .word(op_a), .is_nan(a_nan), .is_snan(a_snan), .is_zero(a_zero),
        .is_sub(a_sub), .is_inf(a_inf), .sign(a_sign)
    );

    serv_fpu_cls u_cls_b (
        .word(op_b), .is_nan(b_nan), .is_snan(b_snan), .is_zero(b_zero),
        .is_sub(b_sub), .is_inf(b_inf), .sign(b_sign)
    );

    assign cls_unused = b_sub ^ b_inf;
    assign a_norm     = ~(a_nan | a_inf | a_zero | a_sub);
    assign any_nan    = a_nan | b_nan;
    assign any_snan   = a_snan | b_snan;
    assign both_zero  = a_zero & b_zero;
    assign exec_done  = (state == ST_EXEC) && (cnt == CNT_LAST);

    assign fclass = {a_nan & ~a_snan, a_snan,
                     ~a_sign & a_inf, ~a_sign & a_norm, ~a_sign & a_sub, ~a_sign & a_zero,
                     a_sign & a_zero, a_sign & a_sub, a_sign & a_norm, a_sign & a_inf};

    // Sign-magnitude ordering where -0 sits below +0 (what min/max want);
    // the compare ops separately treat the two zeros as equal.
    always_comb begin
        if (a_sign != b_sign) begin
            lt_ord = a_sign;
        end else if (a_sign) begin
            lt_ord = op_a[30:0] > op_b[30:0];
        end else begin
            lt_ord = op_a[30:0] < op_b[30:0];
        end
        flt = lt_ord & ~both_zero;
        feq = both_zero | (op_a == op_b);
    end

    always_comb begin
        result   = 32'd0;
        op_flags = 5'd0;
        case (op_f5)
            F5_SGNJ: begin
                case (op_f3)
                    3'b000:  result = {op_b[31], op_a[30:0]};
                    3'b001:  result = {~op_b[31], op_a[30:0]};
                    3'b010:  result = {op_a[31] ^ op_b[31], op_a[30:0]};
                    default: result = 32'd0;
                endcase
            end
            F5_MINMAX: begin
                if (op_f3 == 3'b000 || op_f3 == 3'b001) begin
                    op_flags[FLAG_NV] = any_snan;
                    if (a_nan && b_nan) begin
                        result = CANON_NAN;
                    end else if (a_nan) begin
                        result = op_b;
                    end else if (b_nan) begin
                        result = op_a;
                    end else if (op_f3 == 3'b000) begin
                        result = lt_ord ? op_a : op_b;
                    end else begin
                        result = lt_ord ? op_b : op_a;
                    end
                end
            end
            F5_CMP: begin
                case (op_f3)
                    3'b000: begin
                        result[0]         = ~any_nan & (flt | feq);
                        op_flags[FLAG_NV] = any_nan;
                    end
                    3'b001: begin
                        result[0]         = ~any_nan & flt;
                        op_flags[FLAG_NV] = any_nan;
                    end
                    3'b010: begin
                        result[0]         = ~any_nan & feq;
                        op_flags[FLAG_NV] = any_snan;
                    end
                    default: result = 32'd0;
                endcase
            end
            F5_MVXCLS: begin
                if (op_f3 == 3'b000) begin
                    result = op_a;
                end else if (op_f3 == 3'b001) begin
                    result = {22'd0, fclass};
                end
            end
            F5_MVWX: begin
                if (op_f3 == 3'b000) begin
                    result = op_a;
                end
            end
            default: result = 32'd0;
        endcase
    end

    // DRAIN waits for the core to drop i_valid so one request is never served twice.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cnt     <= 2'd0;
            o_ready <= 1'b0;
            o_rd    <= 32'd0;
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            op_f5   <= 5'd0;
            op_f3   <= 3'd0;
        end else begin
            o_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        op_a  <= i_rs1;
                        op_b  <= i_rs2;
                        op_f5 <= i_funct5;
                        op_f3 <= i_funct3;
                        cnt   <= 2'd0;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == CNT_LAST) begin
                        o_rd    <= result;
                        o_ready <= 1'b1;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP:  state <= ST_DRAIN;
                ST_DRAIN: if (!i_valid) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    generate
        if (FLAGS_EN) begin : g_flags
            logic [4:0] fflags;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    fflags <= 5'd0;
                end else begin
                    fflags <= (i_fflags_clr ? 5'd0 : fflags) | (exec_done ? op_flags : 5'd0);
                end
            end
            assign o_fflags = fflags;
        end else begin : g_no_flags
            logic flags_unused;
            assign flags_unused = ^{op_flags, i_fflags_clr};
            assign o_fflags     = 5'd0;
        end
    endgenerate

endmodule
